// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory between two req/done ports.
// Port 0 is the CPU (fetch, lw/sw) and port 1 is the loader/debug path.
// Accesses are serialised. The memory port is registered. Read data is
// captured after the memory's fixed RD_LAT read latency.
// Build option: define MEM_ARB_FIXED_PRI_EN to give port 0 fixed priority.
// Without it (the default), simultaneous requests are granted round-robin.
//
// state  | meaning
// IDLE   | sample req0/req1, grant one and latch its command
// ACCESS | command on the memory port; mem_we asserted here for writes
// WAIT   | read latency countdown; capture mem_rdata when count reaches 1
// DONE   | one-cycle done pulse to the owner, then back to IDLE
module mem_port_arbiter #(
    parameter int N      = 32,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         we0,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] wdata0,
    output logic         done0,
    output logic [N-1:0] rdata0,
    input  logic         req1,
    input  logic         we1,
    input  logic [N-1:0] addr1,
    input  logic [N-1:0] wdata1,
    output logic         done1,
    output logic [N-1:0] rdata1,
    output logic         busy,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [N-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    localparam int            CW       = 3;
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mem_addr_q, mem_addr_d;
    logic [N-1:0]  mem_wdata_q, mem_wdata_d;
    logic [N-1:0]  rdata0_q, rdata0_d;
    logic [N-1:0]  rdata1_q, rdata1_d;
    logic          pick1;

    // Choose which port wins when sampling requests in IDLE.
    always_comb begin
`ifdef MEM_ARB_FIXED_PRI_EN
        pick1 = req1 & ~req0;
`else
        // last_q=1 means port 1 was served last, so port 0 gets the tie.
        pick1 = req1 & (~req0 | ~last_q);
`endif
    end

    // Next-state logic: arbitration, latency countdown and read data capture.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    owner_d     = pick1;
                    last_d      = pick1;
                    we_d        = pick1 ? we1 : we0;
                    mem_addr_d  = pick1 ? addr1 : addr0;
                    mem_wdata_d = pick1 ? wdata1 : wdata0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    if (owner_q) rdata1_d = mem_rdata;
                    else         rdata0_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    // Outputs. Strobes are gated by rst so an aborted access emits nothing.
    always_comb begin
        busy      = (state_q != IDLE);
        mem_we    = rst & (state_q == ACCESS) & we_q;
        done0     = rst & (state_q == DONE) & ~owner_q;
        done1     = rst & (state_q == DONE) & owner_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        rdata0    = rdata0_q;
        rdata1    = rdata1_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut_a uses RD_LAT=1 and dut_b uses RD_LAT=3.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req0, a_we0, a_done0, a_req1, a_we1, a_done1, a_busy, a_mem_we;
    logic [31:0] a_addr0, a_wdata0, a_rdata0, a_addr1, a_wdata1, a_rdata1;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        b_req0, b_we0, b_done0, b_req1, b_we1, b_done1, b_busy, b_mem_we;
    logic [31:0] b_addr0, b_wdata0, b_rdata0, b_addr1, b_wdata1, b_rdata1;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.N(32), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0),
        .done0(a_done0), .rdata0(a_rdata0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1),
        .done1(a_done1), .rdata1(a_rdata1),
        .busy(a_busy), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.N(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0),
        .done0(b_done0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1),
        .done1(b_done1), .rdata1(b_rdata1),
        .busy(b_busy), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
    );

    // Read-only memory contents: one fixed test word, otherwise address-derived.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h20) ? 32'h1234_5678 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory models: data valid RD_LAT cycles after the address is presented.
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        a_pipe    <= a_mem_addr;
        b_pipe[0] <= b_mem_addr;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_rdata = mem_f(a_pipe);
    assign b_mem_rdata = mem_f(b_pipe[2]);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_rd0, exp_rd1;
        logic        exp_own [4];
        int          n, pulses, busy_cnt;

`ifdef MEM_ARB_FIXED_PRI_EN
        exp_own = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;

        // Reset held two cycles while both ports of dut_a request reads.
        rst = 1'b0;
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h100; a_wdata0 = 32'h0;
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 32'h200; a_wdata1 = 32'h0;
        b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 32'h0;   b_wdata0 = 32'h0;
        b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = 32'h0;   b_wdata1 = 32'h0;
        tick();
        check("rst_busy", a_busy, 1'b0);
        check("rst_done0", a_done0, 1'b0);
        check("rst_done1", a_done1, 1'b0);
        check("rst_mem_we", a_mem_we, 1'b0);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_wdata", a_mem_wdata, 32'h0);
        check("rst_rdata0", a_rdata0, 32'h0);
        check("rst_rdata1", a_rdata1, 32'h0);
        tick();
        check("rst2_busy", a_busy, 1'b0);
        check("rst2_b_busy", b_busy, 1'b0);

        // Release: this IDLE cycle samples both requests; port 0 must win.
        rst = 1'b1;
        tick();
        check("first_grant_busy", a_busy, 1'b1);
        check("first_grant_addr", a_mem_addr, 32'h100);

        // Continuous contention: four completions in arbitration order.
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(a_done0 | a_done1) && n < 8);
            check("cont_done_seen", a_done0 | a_done1, 1'b1);
            check("cont_owner", a_done1, exp_own[k]);
            check("cont_excl", a_done0 & a_done1, 1'b0);
            if (exp_own[k]) exp_rd1 = mem_f(32'h200);
            else            exp_rd0 = mem_f(32'h100);
            check("cont_rdata0", a_rdata0, exp_rd0);
            check("cont_rdata1", a_rdata1, exp_rd1);
            if (k == 3) begin
                a_req0 = 1'b0;
                a_req1 = 1'b0;
            end
        end
        tick();
        check("cont_idle", a_busy, 1'b0);

        // Single write on port 0.
        a_req0 = 1'b1; a_we0 = 1'b1; a_addr0 = 32'h10; a_wdata0 = 32'hDEAD_BEEF;
        check("wr_c0_mem_we", a_mem_we, 1'b0);
        tick();
        check("wr_c1_mem_we", a_mem_we, 1'b1);
        check("wr_c1_mem_addr", a_mem_addr, 32'h10);
        check("wr_c1_mem_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        check("wr_c1_done0", a_done0, 1'b0);
        tick();
        check("wr_c2_done0", a_done0, 1'b1);
        check("wr_c2_done1", a_done1, 1'b0);
        check("wr_c2_mem_we", a_mem_we, 1'b0);
        a_req0 = 1'b0; a_we0 = 1'b0;
        tick();
        check("wr_c3_done0", a_done0, 1'b0);
        check("wr_c3_busy", a_busy, 1'b0);
        check("wr_rdata0", a_rdata0, exp_rd0);

        // Port 1 read of 0x20 on both instances (RD_LAT 1 and 3).
        a_req1 = 1'b1; a_we1 = 1'b0; a_addr1 = 32'h20;
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 32'h20;
        tick();
        tick();
        check("rd1_c2_done1", a_done1, 1'b0);
        tick();
        check("rd1_c3_done1", a_done1, 1'b1);
        check("rd1_c3_rdata1", a_rdata1, 32'h1234_5678);
        check("rd1_c3_rdata0", a_rdata0, exp_rd0);
        check("rd3_c3_done1", b_done1, 1'b0);
        a_req1 = 1'b0;
        tick();
        check("rd3_c4_done1", b_done1, 1'b0);
        tick();
        check("rd3_c5_done1", b_done1, 1'b1);
        check("rd3_c5_rdata1", b_rdata1, 32'h1234_5678);
        check("rd3_c5_rdata0", b_rdata0, 32'h0);
        b_req1 = 1'b0;
        tick();

        // Reset during WAIT on dut_b aborts the read.
        b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 32'h30;
        tick();
        tick();
        check("abort_in_wait_busy", b_busy, 1'b1);
        rst = 1'b0;
        b_req0 = 1'b0;
        #1;
        check("abort_rst_done0", b_done0, 1'b0);
        tick();
        check("abort_busy", b_busy, 1'b0);
        check("abort_rdata0", b_rdata0, 32'h0);
        check("abort_mem_we", b_mem_we, 1'b0);
        rst = 1'b1;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (b_done0) pulses++;
        end
        check("abort_no_done", pulses, 0);

        // The next request after the abort completes normally in cycle 5.
        b_req0 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b_done0 && n < 12);
        check("after_abort_latency", n, 5);
        check("after_abort_rdata0", b_rdata0, mem_f(32'h30));
        b_req0 = 1'b0;
        tick();

        // req0 dropped after grant: latched address is used, one done only.
        a_req0 = 1'b1; a_we0 = 1'b0; a_addr0 = 32'h44;
        tick();
        check("drop_c1_addr", a_mem_addr, 32'h44);
        a_req0 = 1'b0; a_addr0 = 32'h99;
        tick();
        check("drop_c2_addr", a_mem_addr, 32'h44);
        check("drop_c2_done0", a_done0, 1'b0);
        tick();
        check("drop_c3_done0", a_done0, 1'b1);
        check("drop_c3_rdata0", a_rdata0, mem_f(32'h44));
        pulses = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_done0) pulses++;
            if (a_busy) busy_cnt++;
        end
        check("drop_single_done", pulses, 0);
        check("drop_no_second_txn", busy_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
